tree_op_scheduler: RTL and testbench
====================================

TREE_OP_SCHEDULER -- requirements
Module: tree_op_scheduler

Interface
REQ-001 The block SHALL have parameter LEVEL, default 4: number of RPUs and of requester ports; power of two, at least 2.
REQ-002 The block SHALL have parameter TREE_NUM, default 8: number of logical trees; TREE_NUM_BITS = $clog2(TREE_NUM), LEVEL_BITS = $clog2(LEVEL).
REQ-003 The block SHALL have parameter PTW, default 16: push payload width.
REQ-004 The block SHALL have parameter GAP, default 2, range 1 to 15: minimum cycles between two issues to the same RPU.
REQ-005 The block SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-006 i_clk  in  1  single clock; all logic on the rising edge.
REQ-007 i_rst  in  1  reset; synchronous and active-high.
REQ-008 i_req_valid  in  LEVEL  per-requester request valid.
REQ-009 i_req_push  in  LEVEL  per-requester request type; 1 = push, 0 = pop.
REQ-010 i_req_tree_id  in  LEVEL*TREE_NUM_BITS  per-requester tree id, flattened; requester k occupies slice k.
REQ-011 i_req_data  in  LEVEL*PTW  per-requester push payload, flattened.
REQ-012 o_req_ready  out  LEVEL  per-requester accept; a request transfers on the cycle where valid and ready are both 1.
REQ-013 i_rpu_busy  in  LEVEL  RPU r is occupied this cycle by cascade traffic from the previous RPU.
REQ-014 o_rpu_push  out  LEVEL  one-cycle root push strobe to RPU r.
REQ-015 o_rpu_pop  out  LEVEL  one-cycle root pop strobe to RPU r.
REQ-016 o_rpu_tree_id  out  LEVEL*TREE_NUM_BITS  tree id issued to RPU r.
REQ-017 o_rpu_push_data  out  LEVEL*PTW  payload issued to RPU r.

Function
REQ-018 A request's target RPU SHALL be tree_id & (LEVEL-1).
REQ-019 RPU r SHALL be eligible only when its cooldown counter is 0, i_rpu_busy[r] is 0, and i_rst is 0.
REQ-020 Each eligible RPU SHALL grant at most one requester per cycle: the first valid requester targeting r, searching upward from rr_ptr[r] modulo LEVEL.
REQ-021 o_req_ready[k] SHALL be combinational from the grant and SHALL be 1 only for the granted requester.
REQ-022 Grants to different RPUs SHALL be independent, so up to LEVEL grants can occur in one cycle.
REQ-023 On a grant by RPU r to requester k, rr_ptr[r] SHALL become (k+1) mod LEVEL on the next edge.
REQ-024 A grant at cycle t SHALL produce, at cycle t+1 only, o_rpu_push[r] = 1 for a push or o_rpu_pop[r] = 1 for a pop, plus the registered tree id.
REQ-025 o_rpu_push_data[r] SHALL carry the request data for a push, and all-ones for a pop or when idle.
REQ-026 o_rpu_push[r] and o_rpu_pop[r] SHALL never be 1 together.
REQ-027 A grant SHALL load cooldown[r] with GAP-1; a nonzero cooldown SHALL decrement once per cycle; the earliest next grant to r is therefore cycle t+GAP.
REQ-028 GAP = 1 SHALL allow a grant to r on every cycle.
REQ-029 While i_rpu_busy[r] is 1, RPU r SHALL issue no grant and its cooldown SHALL keep counting down.
REQ-030 A requester whose valid is 1 but is not granted SHALL keep its request pending; the block stores no request state.

Reset
REQ-031 While i_rst is 1: o_req_ready = 0, o_rpu_push = 0, o_rpu_pop = 0, o_rpu_tree_id = 0, o_rpu_push_data = all-ones, rr_ptr = 0, cooldown = 0, statistics counters = 0.
REQ-032 A grant evaluated in a cycle where i_rst is 1 SHALL NOT occur and SHALL produce no RPU strobe.
REQ-033 The first grant SHALL be possible in the first cycle after i_rst falls.

Configuration
REQ-034 With macro TREE_OP_SCHED_STATS_EN defined, the block SHALL add output o_issue_cnt (LEVEL*CNT_W, one issue count per RPU) and output o_stall_cnt (LEVEL*CNT_W).
REQ-035 o_stall_cnt[r] SHALL count cycles where some request targets r but r is not eligible.
REQ-036 Both counters SHALL saturate at all-ones.
REQ-037 Without TREE_OP_SCHED_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification (LEVEL=4, TREE_NUM=8, PTW=16, GAP=2)
REQ-038 Requester 0 pushes tree 5, data 0x1234 -> o_req_ready[0] = 1 in the same cycle; next cycle o_rpu_push[1] = 1, tree id 5, data 0x1234; the strobe lasts one cycle.
REQ-039 Requesters 0, 1 and 2 hold a pop on tree 2 continuously -> RPU 2 grants requesters 0, 1, 2, 0 at cycles t, t+2, t+4, t+6; o_rpu_pop[2] pulses every second cycle.
REQ-040 Request on tree 3 while i_rpu_busy[3] = 1 for 3 cycles -> o_req_ready stays 0 for those cycles; grant in the cycle busy drops; o_rpu_pop[3] the cycle after.
REQ-041 Requesters 0 to 3 push trees 0, 1, 2, 3 in the same cycle -> all four ready in that cycle; all four o_rpu_push bits high next cycle.
REQ-042 i_rst asserted in a cycle with a valid request -> o_req_ready = 0, no strobe next cycle, rr_ptr = 0; the request is granted in the first cycle after reset.
REQ-043 With TREE_OP_SCHED_STATS_EN: three pushes to tree 1 plus one busy cycle with a pending request -> o_issue_cnt[1] = 3, o_stall_cnt[1] >= 1; forcing the count to all-ones then issuing -> the count holds at 0xFFFF.

Source files
------------

// File: rtl/tree_op_scheduler.sv
// Root-operation scheduler: routes push/pop requests to RPU (tree_id mod LEVEL) with per-RPU round-robin and cooldown.
// Optional per-RPU issue/stall statistics are enabled with macro TREE_OP_SCHED_STATS_EN.
module tree_op_scheduler #(
   parameter int LEVEL    = 4,
   parameter int TREE_NUM = 8,
   parameter int PTW      = 16,
   parameter int GAP      = 2,
   parameter int CNT_W    = 16,
   localparam int TREE_NUM_BITS = $clog2(TREE_NUM),
   localparam int LEVEL_BITS    = $clog2(LEVEL)
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [LEVEL-1:0]                i_req_valid,
   input  logic [LEVEL-1:0]                i_req_push,
   input  logic [LEVEL*TREE_NUM_BITS-1:0]  i_req_tree_id,
   input  logic [LEVEL*PTW-1:0]            i_req_data,
   output logic [LEVEL-1:0]                o_req_ready,
   input  logic [LEVEL-1:0]                i_rpu_busy,
`ifdef TREE_OP_SCHED_STATS_EN
   output logic [LEVEL*CNT_W-1:0]          o_issue_cnt,
   output logic [LEVEL*CNT_W-1:0]          o_stall_cnt,
`endif
   output logic [LEVEL-1:0]                o_rpu_push,
   output logic [LEVEL-1:0]                o_rpu_pop,
   output logic [LEVEL*TREE_NUM_BITS-1:0]  o_rpu_tree_id,
   output logic [LEVEL*PTW-1:0]            o_rpu_push_data
);

   localparam int CDW = 4;

   logic [LEVEL-1:0][LEVEL_BITS-1:0]    rr_ptr_q, rr_ptr_d;
   logic [LEVEL-1:0][CDW-1:0]           cool_q, cool_d;
   logic [LEVEL-1:0]                    push_q, push_d, pop_q, pop_d;
   logic [LEVEL-1:0][TREE_NUM_BITS-1:0] tid_q, tid_d;
   logic [LEVEL-1:0][PTW-1:0]           data_q, data_d;
   logic [LEVEL-1:0]                    eligible, gnt_vld, pend;
   logic [LEVEL-1:0][LEVEL_BITS-1:0]    gnt_idx, tgt;
   logic [LEVEL_BITS-1:0]               idx;

   always_comb begin
      for (int k = 0; k < LEVEL; k++)
         tgt[k] = i_req_tree_id[k*TREE_NUM_BITS +: LEVEL_BITS];
   end

   // Per-RPU arbitration; the first matching requester at or after rr_ptr wins.
   always_comb begin
      eligible = '0;
      gnt_vld  = '0;
      gnt_idx  = '0;
      pend     = '0;
      idx      = '0;
      for (int r = 0; r < LEVEL; r++) begin
         eligible[r] = (cool_q[r] == '0) && !i_rpu_busy[r] && !i_rst;
         for (int off = 0; off < LEVEL; off++) begin
            idx = rr_ptr_q[r] + LEVEL_BITS'(off);
            if (i_req_valid[idx] && (tgt[idx] == LEVEL_BITS'(r))) begin
               pend[r] = 1'b1;
               if (eligible[r] && !gnt_vld[r]) begin
                  gnt_vld[r] = 1'b1;
                  gnt_idx[r] = idx;
               end
            end
         end
      end
   end

   always_comb begin
      o_req_ready = '0;
      for (int r = 0; r < LEVEL; r++)
         if (gnt_vld[r]) o_req_ready[gnt_idx[r]] = 1'b1;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      cool_d   = cool_q;
      push_d   = '0;
      pop_d    = '0;
      tid_d    = '0;
      data_d   = '1;
      for (int r = 0; r < LEVEL; r++) begin
         if (cool_q[r] != '0) cool_d[r] = cool_q[r] - CDW'(1);
         if (gnt_vld[r]) begin
            rr_ptr_d[r] = gnt_idx[r] + LEVEL_BITS'(1);
            cool_d[r]   = CDW'(GAP - 1);
            push_d[r]   = i_req_push[gnt_idx[r]];
            pop_d[r]    = !i_req_push[gnt_idx[r]];
            tid_d[r]    = i_req_tree_id[int'(gnt_idx[r])*TREE_NUM_BITS +: TREE_NUM_BITS];
            if (i_req_push[gnt_idx[r]]) data_d[r] = i_req_data[int'(gnt_idx[r])*PTW +: PTW];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rr_ptr_q <= '0;
         cool_q   <= '0;
         push_q   <= '0;
         pop_q    <= '0;
         tid_q    <= '0;
         data_q   <= '1;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         cool_q   <= cool_d;
         push_q   <= push_d;
         pop_q    <= pop_d;
         tid_q    <= tid_d;
         data_q   <= data_d;
      end
   end

   assign o_rpu_push      = push_q;
   assign o_rpu_pop       = pop_q;
   assign o_rpu_tree_id   = tid_q;
   assign o_rpu_push_data = data_q;

`ifdef TREE_OP_SCHED_STATS_EN
   logic [LEVEL-1:0][CNT_W-1:0] issue_cnt_q, issue_cnt_d, stall_cnt_q, stall_cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // A stall is a cycle with pending work for r that r cannot accept.
   always_comb begin
      issue_cnt_d = issue_cnt_q;
      stall_cnt_d = stall_cnt_q;
      for (int r = 0; r < LEVEL; r++) begin
         if (gnt_vld[r])                issue_cnt_d[r] = sat_inc(issue_cnt_q[r]);
         if (pend[r] && !eligible[r])   stall_cnt_d[r] = sat_inc(stall_cnt_q[r]);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign o_issue_cnt = issue_cnt_q;
   assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tree_op_scheduler.sv
// Scoreboard bench for tree_op_scheduler (LEVEL=4, TREE_NUM=8, PTW=16, GAP=2).
// Define TREE_OP_SCHED_STATS_EN to also exercise the statistics counters.
module tb_tree_op_scheduler;
   localparam int LEVEL = 4;
   localparam int TNB   = 3;
   localparam int PTW   = 16;
   localparam int CNT_W = 16;

   logic i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   logic                   i_rst = 1'b1;
   logic [LEVEL-1:0]       i_req_valid = '0;
   logic [LEVEL-1:0]       i_rpu_busy  = '0;
   logic [LEVEL-1:0]       o_req_ready, o_rpu_push, o_rpu_pop;
   logic [LEVEL*TNB-1:0]   o_rpu_tree_id;
   logic [LEVEL*PTW-1:0]   o_rpu_push_data;
`ifdef TREE_OP_SCHED_STATS_EN
   logic [LEVEL*CNT_W-1:0] o_issue_cnt, o_stall_cnt;
`endif

   logic             push_a [LEVEL] = '{default: 1'b0};
   logic [TNB-1:0]   tid_a  [LEVEL] = '{default: '0};
   logic [PTW-1:0]   dat_a  [LEVEL] = '{default: '0};
   logic             nx_push[LEVEL] = '{default: 1'b0};
   logic [TNB-1:0]   nx_tid [LEVEL] = '{default: '0};
   logic [PTW-1:0]   nx_dat [LEVEL] = '{default: '0};

   logic [LEVEL-1:0]     i_req_push;
   logic [LEVEL*TNB-1:0] i_req_tree_id;
   logic [LEVEL*PTW-1:0] i_req_data;
   always_comb begin
      for (int k = 0; k < LEVEL; k++) begin
         i_req_push[k]              = push_a[k];
         i_req_tree_id[k*TNB +: TNB] = tid_a[k];
         i_req_data[k*PTW +: PTW]    = dat_a[k];
      end
   end

   tree_op_scheduler dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req_valid(i_req_valid), .i_req_push(i_req_push),
      .i_req_tree_id(i_req_tree_id), .i_req_data(i_req_data),
      .o_req_ready(o_req_ready), .i_rpu_busy(i_rpu_busy),
`ifdef TREE_OP_SCHED_STATS_EN
      .o_issue_cnt(o_issue_cnt), .o_stall_cnt(o_stall_cnt),
`endif
      .o_rpu_push(o_rpu_push), .o_rpu_pop(o_rpu_pop),
      .o_rpu_tree_id(o_rpu_tree_id), .o_rpu_push_data(o_rpu_push_data)
   );

   typedef struct {
      int           c;
      int           r;
      bit           push;
      logic [TNB-1:0] tid;
      logic [PTW-1:0] data;
   } exp_t;
   exp_t sbq[$];

   int total = 0;
   int bad   = 0;

   task automatic set_req(input int k, input bit p, input logic [TNB-1:0] t, input logic [PTW-1:0] d);
      nx_push[k] = p;
      nx_tid[k]  = t;
      nx_dat[k]  = d;
   endtask

   // One cycle: apply staged request fields plus valid/busy/rst, check ready, queue expected strobes.
   task automatic step(input logic [LEVEL-1:0] v, input logic [LEVEL-1:0] b, input logic rs,
                       input logic [LEVEL-1:0] exp_rdy, input string nm);
      @(posedge i_clk);
      #1;
      for (int k = 0; k < LEVEL; k++) begin
         push_a[k] = nx_push[k];
         tid_a[k]  = nx_tid[k];
         dat_a[k]  = nx_dat[k];
      end
      i_req_valid = v;
      i_rpu_busy  = b;
      i_rst       = rs;
      @(negedge i_clk);
      total++;
      if (o_req_ready !== exp_rdy) begin
         bad++;
         $display("FAIL %s ready got=%b exp=%b (cycle %0d)", nm, o_req_ready, exp_rdy, cyc);
      end
      for (int k = 0; k < LEVEL; k++)
         if (exp_rdy[k])
            sbq.push_back('{c: cyc + 1, r: int'(tid_a[k][1:0]), push: push_a[k], tid: tid_a[k],
                            data: push_a[k] ? dat_a[k] : 16'hFFFF});
   endtask

   // Monitor: every strobe must match a queued expectation; idle RPUs show all-ones data.
   always @(negedge i_clk) begin
      for (int r = 0; r < LEVEL; r++) begin
         total++;
         if (o_rpu_push[r] && o_rpu_pop[r]) begin
            bad++;
            $display("FAIL both_strobes rpu=%0d push=1 pop=1 required exclusive", r);
         end
         if (o_rpu_push[r] || o_rpu_pop[r]) begin
            int hit;
            hit = -1;
            for (int i = 0; i < sbq.size(); i++)
               if (hit < 0 && sbq[i].c == cyc && sbq[i].r == r) hit = i;
            total++;
            if (hit < 0) begin
               bad++;
               $display("FAIL unexpected_strobe rpu=%0d cycle=%0d push=%b pop=%b required none",
                        r, cyc, o_rpu_push[r], o_rpu_pop[r]);
            end else begin
               if (o_rpu_push[r] !== sbq[hit].push || o_rpu_pop[r] !== !sbq[hit].push ||
                   o_rpu_tree_id[r*TNB +: TNB] !== sbq[hit].tid ||
                   o_rpu_push_data[r*PTW +: PTW] !== sbq[hit].data) begin
                  bad++;
                  $display("FAIL issue rpu=%0d got push=%b tid=%0d data=%h required push=%b tid=%0d data=%h",
                           r, o_rpu_push[r], o_rpu_tree_id[r*TNB +: TNB], o_rpu_push_data[r*PTW +: PTW],
                           sbq[hit].push, sbq[hit].tid, sbq[hit].data);
               end
               sbq.delete(hit);
            end
         end else begin
            total++;
            if (o_rpu_push_data[r*PTW +: PTW] !== 16'hFFFF) begin
               bad++;
               $display("FAIL idle_data rpu=%0d got=%h required=ffff", r, o_rpu_push_data[r*PTW +: PTW]);
            end
         end
      end
      for (int i = sbq.size() - 1; i >= 0; i--)
         if (sbq[i].c < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_strobe rpu=%0d expected at cycle %0d", sbq[i].r, sbq[i].c);
            sbq.delete(i);
         end
   end

   initial begin
      // Reset with nothing pending.
      step(4'b0000, 4'b0000, 1'b1, 4'b0000, "reset_idle");
      step(4'b0000, 4'b0000, 1'b1, 4'b0000, "reset_idle2");

      // Single push, tree 5 -> RPU 1, granted on the first cycle after reset.
      set_req(0, 1'b1, 3'd5, 16'h1234);
      step(4'b0001, 4'b0000, 1'b0, 4'b0001, "push_t5");
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, "push_t5_done");

      // Three requesters hold a pop on tree 2: round robin every GAP cycles.
      for (int k = 0; k < 3; k++) set_req(k, 1'b0, 3'd2, 16'h0000);
      step(4'b0111, 4'b0000, 1'b0, 4'b0001, "rr_t");
      step(4'b0111, 4'b0000, 1'b0, 4'b0000, "rr_t1_cool");
      step(4'b0111, 4'b0000, 1'b0, 4'b0010, "rr_t2");
      step(4'b0111, 4'b0000, 1'b0, 4'b0000, "rr_t3_cool");
      step(4'b0111, 4'b0000, 1'b0, 4'b0100, "rr_t4");
      step(4'b0111, 4'b0000, 1'b0, 4'b0000, "rr_t5_cool");
      step(4'b0111, 4'b0000, 1'b0, 4'b0001, "rr_t6_wrap");
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, "rr_idle");

      // Pop on tree 3 blocked by busy, then granted; cooldown runs during busy.
      set_req(0, 1'b0, 3'd3, 16'h5555);
      step(4'b0001, 4'b1000, 1'b0, 4'b0000, "busy_1");
      step(4'b0001, 4'b1000, 1'b0, 4'b0000, "busy_2");
      step(4'b0001, 4'b1000, 1'b0, 4'b0000, "busy_3");
      step(4'b0001, 4'b0000, 1'b0, 4'b0001, "busy_drop");
      step(4'b0001, 4'b1000, 1'b0, 4'b0000, "busy_after");
      step(4'b0001, 4'b0000, 1'b0, 4'b0001, "cool_in_busy");
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, "busy_idle");

      // Four simultaneous pushes to four different RPUs (upper tree bits ignored for routing).
      set_req(0, 1'b1, 3'd4, 16'hA000);
      set_req(1, 1'b1, 3'd1, 16'hA001);
      set_req(2, 1'b1, 3'd6, 16'hA002);
      set_req(3, 1'b1, 3'd3, 16'hA003);
      step(4'b1111, 4'b0000, 1'b0, 4'b1111, "all_four");
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, "all_four_idle");

      // Reset during a valid request clears rr_ptr[0] (was 1), so requester 0 wins first after reset.
      set_req(0, 1'b1, 3'd0, 16'hB000);
      set_req(1, 1'b1, 3'd4, 16'hB001);
      step(4'b0011, 4'b0000, 1'b1, 4'b0000, "rst_req");
      step(4'b0011, 4'b0000, 1'b1, 4'b0000, "rst_req2");
      step(4'b0011, 4'b0000, 1'b0, 4'b0001, "post_rst_first");
      step(4'b0010, 4'b0000, 1'b0, 4'b0000, "post_rst_cool");
      step(4'b0010, 4'b0000, 1'b0, 4'b0010, "post_rst_second");
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, "post_rst_idle");

`ifdef TREE_OP_SCHED_STATS_EN
      set_req(2, 1'b1, 3'd1, 16'hC000);
      step(4'b0100, 4'b0000, 1'b0, 4'b0100, "st_push1");
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, "st_gap1");
      step(4'b0100, 4'b0000, 1'b0, 4'b0100, "st_push2");
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, "st_gap2");
      step(4'b0100, 4'b0000, 1'b0, 4'b0100, "st_push3");
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, "st_gap3");
      step(4'b0100, 4'b0010, 1'b0, 4'b0000, "st_busy");
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, "st_idle");
      total++;
      if (o_issue_cnt[1*CNT_W +: CNT_W] !== 16'd3) begin
         bad++;
         $display("FAIL issue_cnt1 got=%0d required=3", o_issue_cnt[1*CNT_W +: CNT_W]);
      end
      total++;
      if (o_stall_cnt[1*CNT_W +: CNT_W] < 16'd1) begin
         bad++;
         $display("FAIL stall_cnt1 got=%0d required>=1", o_stall_cnt[1*CNT_W +: CNT_W]);
      end
      force dut.issue_cnt_q = {LEVEL*CNT_W{1'b1}};
      #1;
      release dut.issue_cnt_q;
      step(4'b0100, 4'b0000, 1'b0, 4'b0100, "st_sat_push");
      step(4'b0000, 4'b0000, 1'b0, 4'b0000, "st_sat_idle");
      total++;
      if (o_issue_cnt[1*CNT_W +: CNT_W] !== 16'hFFFF) begin
         bad++;
         $display("FAIL issue_cnt_sat got=%h required=ffff", o_issue_cnt[1*CNT_W +: CNT_W]);
      end
`endif

      repeat (3) @(negedge i_clk);
      #1;
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL leftover_expect got=%0d required=0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
